// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for the pulse-train sequencer.
// Holds the state encoding, default field widths and the configuration bundle.
package pulse_sched_pkg;

  localparam int TW_DEF = 8;
  localparam int CW_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    HIGH,
    LOW,
    FIN
  } state_t;

  typedef struct packed {
    logic [TW_DEF-1:0] delay;
    logic [TW_DEF-1:0] high;
    logic [TW_DEF-1:0] low;
    logic [CW_DEF-1:0] count;
  } cfg_t;

  // A phase of W cycles loads W-1; a zero width still lasts one cycle.
  function automatic logic [TW_DEF-1:0] phase_load(input logic [TW_DEF-1:0] width);
    return (width == '0) ? '0 : width - 1'b1;
  endfunction

endpackage

// File: rtl/pulse_sched_timer.sv
// Loadable down-counter shared by the delay, high and low phases.
// expired_o is high while the count sits at zero.
module pulse_sched_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          en_i,
  input  logic [TW-1:0] load_val_i,
  output logic          expired_o
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_scheduler.sv
// Pulse-train sequencer: after start, waits a delay then emits N pulses of set high/low width.
// Defining PULSE_SCHED_ABORT_EN adds an abort input that cuts a running train short.
//   state | meaning
//   IDLE  | waiting for start
//   DELAY | pre-pulse delay
//   HIGH  | pulse driven high
//   LOW   | gap between pulses
//   FIN   | one-cycle done strobe
module pulse_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int TW = TW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
`ifdef PULSE_SCHED_ABORT_EN
  input  logic          abort,
`endif
  input  logic [TW-1:0] cfg_delay,
  input  logic [TW-1:0] cfg_high,
  input  logic [TW-1:0] cfg_low,
  input  logic [CW-1:0] cfg_count,
  output logic          pulse,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] pulse_cnt
);

  state_t        state_q;
  logic          pulse_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] pulse_cnt_q;
  logic [CW-1:0] count_q;
  logic [TW-1:0] high_q;
  logic [TW-1:0] low_q;

  cfg_t          cfg_in;
  logic          abort_hit;
  logic          last_pulse;
  logic          tmr_load;
  logic          tmr_en;
  logic          tmr_expired;
  logic [TW-1:0] tmr_val;

  assign cfg_in = '{delay: cfg_delay, high: cfg_high, low: cfg_low, count: cfg_count};

`ifdef PULSE_SCHED_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // pulse_cnt_q never reaches count_q while a pulse is still pending, so +1 cannot wrap.
  assign last_pulse = ((pulse_cnt_q + 1'b1) == count_q);

  always_comb begin
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          tmr_load = 1'b1;
          tmr_val  = (cfg_in.delay != '0) ? cfg_in.delay - 1'b1 : phase_load(cfg_in.high);
        end
      end
      DELAY, LOW: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          tmr_val  = phase_load(high_q);
        end else begin
          tmr_en = 1'b1;
        end
      end
      HIGH: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          tmr_val  = phase_load(low_q);
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  pulse_sched_timer #(.TW(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .en_i       (tmr_en),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pulse_cnt_q <= '0;
      count_q     <= '0;
      high_q      <= '0;
      low_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            high_q      <= cfg_in.high;
            low_q       <= cfg_in.low;
            count_q     <= cfg_in.count;
            pulse_cnt_q <= '0;
            busy_q      <= 1'b1;
            if (cfg_in.count == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else if (cfg_in.delay != '0) begin
              state_q <= DELAY;
            end else begin
              state_q <= HIGH;
              pulse_q <= 1'b1;
            end
          end
        end
        DELAY: begin
          if (abort_hit) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else if (tmr_expired) begin
            state_q <= HIGH;
            pulse_q <= 1'b1;
          end
        end
        HIGH: begin
          if (abort_hit) begin
            pulse_q <= 1'b0;
            state_q <= FIN;
            done_q  <= 1'b1;
          end else if (tmr_expired) begin
            pulse_q     <= 1'b0;
            pulse_cnt_q <= pulse_cnt_q + 1'b1;
            if (last_pulse) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= LOW;
            end
          end
        end
        LOW: begin
          if (abort_hit) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else if (tmr_expired) begin
            state_q <= HIGH;
            pulse_q <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pulse     = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule
